truth_table_engine: RTL and testbench

//  Programmable, registered truth-table evaluator; generalises the fixed 4-in/10-out decoder.

---
 rtl/truth_table_engine.sv | 91 +++++++++
 tb/tb_truth_table_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_engine.sv
// Programmable 2^IN_W x OUT_W truth table with single lookups and an ordered full-table sweep.
// Latency 1 cycle to a one-entry output register; that register holds under !out_ready, which stalls lookups and sweep.
module truth_table_engine #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    output logic             cfg_err,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_bits,
    output logic             in_ready,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_bits,
    output logic [IN_W-1:0]  out_index
);
    localparam int DEPTH = 2 ** IN_W;
    localparam logic [IN_W:0] LAST_ROW = (IN_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t           state;
    logic [OUT_W-1:0] tbl [DEPTH];
    logic [IN_W:0]    cnt;
    logic             out_free;
    logic             lookup;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free;
    assign lookup   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_bits   <= '0;
            out_index  <= '0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            cfg_err    <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    // Lookup reads the pre-write row; the write lands on the same edge.
                    if (cfg_we) tbl[cfg_addr] <= cfg_data;
                    if (lookup) begin
                        out_bits  <= tbl[in_bits];
                        out_index <= in_bits;
                        out_valid <= 1'b1;
                    end else if (sweep_start) begin
                        state      <= SWEEP;
                        cnt        <= '0;
                        sweep_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (cfg_we) cfg_err <= 1'b1;
                    if (out_free) begin
                        out_bits  <= tbl[cnt[IN_W-1:0]];
                        out_index <= cnt[IN_W-1:0];
                        out_valid <= 1'b1;
                        cnt       <= cnt + 1'b1;
                        if (cnt == LAST_ROW) state <= DONE;
                    end
                end
                DONE: begin
                    if (cfg_we) cfg_err <= 1'b1;
                    if (out_valid && out_ready) begin
                        sweep_done <= 1'b1;
                        sweep_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_engine.sv
// Bench for truth_table_engine: directed scenarios plus a negedge monitor against a queue-based reference.
module tb_truth_table_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [9:0] cfg_data = '0;
    logic       cfg_err;
    logic       in_valid = 1'b0;
    logic [3:0] in_bits = '0;
    logic       in_ready;
    logic       sweep_start = 1'b0;
    logic       sweep_busy;
    logic       sweep_done;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] out_bits;
    logic [3:0] out_index;

    int total = 0;
    int bad = 0;

    truth_table_engine #(.IN_W(4), .OUT_W(10)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_index(out_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: table contents plus the ordered list of beats still owed downstream.
    typedef struct packed {
        logic       sw;
        logic [3:0] idx;
        logic [9:0] bits;
    } beat_t;

    logic [9:0] mtab [16];
    beat_t      expq [$];
    beat_t      fb;
    logic       mbusy = 1'b0;
    logic       exp_done = 1'b0;
    logic       exp_err = 1'b0;
    logic       b0, acc;

    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            for (int i = 0; i < 16; i++) mtab[i] = '0;
            mbusy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        end else begin
            chk("mon_sweep_done", 32'(sweep_done), 32'(exp_done));
            chk("mon_cfg_err", 32'(cfg_err), 32'(exp_err));
            chk("mon_sweep_busy", 32'(sweep_busy), 32'(mbusy));
            if (mbusy) chk("mon_in_ready_busy", 32'(in_ready), 32'd0);
            exp_done = 1'b0;
            exp_err  = 1'b0;
            b0  = mbusy;
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("mon_unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    fb = expq[0];
                    chk("mon_out_bits", 32'(out_bits), 32'(fb.bits));
                    chk("mon_out_index", 32'(out_index), 32'(fb.idx));
                    if (out_ready) begin
                        void'(expq.pop_front());
                        if (fb.sw && fb.idx == 4'hF) begin
                            mbusy = 1'b0;
                            exp_done = 1'b1;
                        end
                    end
                end
            end
            if (acc) expq.push_back('{sw: 1'b0, idx: in_bits, bits: mtab[in_bits]});
            if (cfg_we) begin
                if (b0) exp_err = 1'b1;
                else mtab[cfg_addr] = cfg_data;
            end
            if (sweep_start && !acc && !b0) begin
                for (int i = 0; i < 16; i++) expq.push_back('{sw: 1'b1, idx: 4'(i), bits: mtab[i]});
                mbusy = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_lookup(input logic [3:0] b, output logic [9:0] bits, output logic [3:0] idx);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_bits  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL lookup_timeout: in_ready stayed 0 for row %0h", b);
        end
        tick();
        in_valid = 1'b0;
        chk("lookup_out_valid", 32'(out_valid), 32'd1);
        bits = out_bits;
        idx  = out_index;
    endtask

    task automatic start_sweep();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
    endtask

    logic [9:0] pat [16];
    logic [9:0] rb;
    logic [3:0] ri;
    logic [9:0] got3;
    int beats, first, last, donec, nexp, order_bad, nz, dcnt;
    logic seen;

    initial begin
        pat = '{10'h020, 10'h1A4, 10'h2C9, 10'h033, 10'h099, 10'h012, 10'h002, 10'h001,
                10'h000, 10'h018, 10'h008, 10'h060, 10'h231, 10'h042, 10'h030, 10'h038};
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bits", 32'(out_bits), 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_sweep_busy", 32'(sweep_busy), 32'd0);
        chk("rst_sweep_done", 32'(sweep_done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: lookup of an unwritten row after reset
        out_ready = 1'b1;
        do_lookup(4'hF, rb, ri);
        chk("t1_bits", 32'(rb), 32'h000);
        chk("t1_index", 32'(ri), 32'hF);
        tick();

        // 2: program the table and sweep it without backpressure
        for (int i = 0; i < 16; i++) begin
            cfg_we = 1'b1; cfg_addr = 4'(i); cfg_data = pat[i];
            tick();
        end
        cfg_we = 1'b0;
        start_sweep();
        beats = 0; first = -1; last = -1; donec = -1; got3 = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (first < 0) first = c;
                last = c;
                beats++;
                if (out_index == 4'h3) got3 = out_bits;
            end
            if (sweep_done) begin donec = c; break; end
        end
        chk("t2_beats", 32'(beats), 32'd16);
        chk("t2_consecutive", 32'(last - first), 32'd15);
        chk("t2_done_timing", 32'(donec), 32'(last + 1));
        chk("t2_row3", 32'(got3), 32'h033);
        tick();

        // 3: held output under backpressure
        out_ready = 1'b0;
        do_lookup(4'h5, rb, ri);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_bits", 32'(out_bits), 32'h012);
            chk("t3_hold_index", 32'(out_index), 32'h5);
            chk("t3_in_ready_low", 32'(in_ready), 32'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_in_ready_freed", 32'(in_ready), 32'd1);
        tick();
        chk("t3_consumed", 32'(out_valid), 32'd0);

        // 4: write and lookup of the same row on the same edge
        cfg_we = 1'b1; cfg_addr = 4'h7; cfg_data = 10'h3FF;
        in_valid = 1'b1; in_bits = 4'h7;
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("t4_old_value", 32'(out_bits), 32'h001);
        tick();
        do_lookup(4'h7, rb, ri);
        chk("t4_new_value", 32'(rb), 32'h3FF);
        tick();

        // 5: rejected write mid-sweep, random backpressure
        start_sweep();
        cfg_we = 1'b1; cfg_addr = 4'h2; cfg_data = 10'h155;
        tick();
        cfg_we = 1'b0;
        chk("t5_cfg_err", 32'(cfg_err), 32'd1);
        beats = 0; nexp = 0; order_bad = 0; seen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (int'(out_index) != nexp) order_bad++;
                nexp++;
                beats++;
            end
            if (sweep_done) begin seen = 1'b1; break; end
            tick();
            out_ready = 1'($urandom_range(0, 1));
        end
        chk("t5_done_seen", 32'(seen), 32'd1);
        chk("t5_beats", 32'(beats), 32'd16);
        chk("t5_order", 32'(order_bad), 32'd0);
        tick();
        out_ready = 1'b1;
        do_lookup(4'h2, rb, ri);
        chk("t5_row_unchanged", 32'(rb), 32'h2C9);
        tick();

        // 6: reset in the middle of a sweep
        start_sweep();
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid && out_index == 4'h6) begin seen = 1'b1; break; end
        end
        chk("t6_reached_row6", 32'(seen), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_sweep_busy", 32'(sweep_busy), 32'd0);
        reset = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sweep_done) dcnt++;
        end
        chk("t6_no_done", 32'(dcnt), 32'd0);
        tick();
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            do_lookup(4'(i), rb, ri);
            if (rb != 10'h000) nz++;
        end
        chk("t6_rows_cleared", 32'(nz), 32'd0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
